// File: rtl/sram_wait_state_memory.sv
// ============================================================================
// sram_wait_state_memory
//
// Purpose:
//    Word-organised SRAM model sitting behind an AXI-Lite SRAM controller.
//    Every access is held for a configurable number of wait states before a
//    one-cycle completion pulse is produced. Only one access can be in flight
//    at a time. Requests that arrive while an access is in flight are dropped.
//    Accesses outside the populated range complete normally but flag an error.
//
// Parameters:
//    DEPTH_WORDS  number of 32-bit words (power of two, 2..65536)
//    WR_LATENCY   cycles from write acceptance to sram_write_done (1..15)
//    RD_LATENCY   cycles from read acceptance to sram_read_done (1..15)
//
// Ports:
//    clock            sole clock, rising edge
//    rst              asynchronous, active-high reset
//    sram_addr        byte address (low two bits ignored)
//    sram_data_in     write data
//    wr_en            write request, sampled every cycle
//    rd_en            read request, sampled every cycle
//    sram_data_out    read data, held until the next read completes
//    sram_write_done  one-cycle write completion pulse
//    sram_read_done   one-cycle read completion pulse
//    sram_err         one-cycle error pulse alongside an out-of-range done
//    busy             high from acceptance through the done cycle
// ============================================================================
module sram_wait_state_memory #(
    parameter int DEPTH_WORDS = 1024,
    parameter int WR_LATENCY  = 1,
    parameter int RD_LATENCY  = 2
) (
    input  logic        clock,
    input  logic        rst,
    input  logic [31:0] sram_addr,
    input  logic [31:0] sram_data_in,
    input  logic        wr_en,
    input  logic        rd_en,
    output logic [31:0] sram_data_out,
    output logic        sram_write_done,
    output logic        sram_read_done,
    output logic        sram_err,
    output logic        busy
);

    localparam int          IDX_W      = $clog2(DEPTH_WORDS);
    localparam logic [31:0] ADDR_LIMIT = 32'(4 * DEPTH_WORDS);
    localparam logic [3:0]  WR_LOAD    = 4'(WR_LATENCY - 1);
    localparam logic [3:0]  RD_LOAD    = 4'(RD_LATENCY - 1);
    localparam logic [31:0] OOR_DATA   = 32'hDEAD_BEEF;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WR_WAIT = 2'd1,
        RD_WAIT = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_stateNext;
    logic [3:0]        r_count;
    logic [3:0]        w_countNext;

    logic [IDX_W-1:0]  r_index;
    logic [31:0]       r_dataIn;
    logic              r_isWrite;
    logic              r_err;
    logic [31:0]       r_dataOut;

    logic [31:0]       r_mem [DEPTH_WORDS];

    logic              w_idle;
    logic              w_accept;
    logic              w_addrInRange;
    logic              w_enterDone;
    logic [IDX_W-1:0]  w_accessIndex;
    logic [31:0]       w_accessData;
    logic              w_accessIsWrite;
    logic              w_accessInRange;

    // Request decode. The range test uses the full 32-bit address so that
    // high address bits never alias back into the array.
    assign w_idle        = (r_state == IDLE);
    assign w_accept      = w_idle && (wr_en || rd_en);
    assign w_addrInRange = (sram_addr < ADDR_LIMIT);

    // The access that completes on the edge entering DONE. With a latency of
    // one, DONE is entered on the accepting edge itself, so the live inputs
    // describe the access; otherwise the values latched at acceptance do.
    assign w_accessIndex   = w_idle ? sram_addr[IDX_W+1:2] : r_index;
    assign w_accessData    = w_idle ? sram_data_in         : r_dataIn;
    assign w_accessIsWrite = w_idle ? wr_en                : r_isWrite;
    assign w_accessInRange = w_idle ? w_addrInRange        : !r_err;

    // Gated by rst so that nothing is committed while reset is held, even
    // though the memory array itself is never reset.
    assign w_enterDone = !rst && (w_stateNext == DONE) && (r_state != DONE);

    // State and wait-counter registers.
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_count <= 4'd0;
        end else begin
            r_state <= w_stateNext;
            r_count <= w_countNext;
        end
    end

    // Next-state logic. On acceptance the counter loads LATENCY-1; a zero
    // load goes straight to DONE so the done pulse lands in the cycle right
    // after the accepting edge. In the wait states the counter decrements and
    // the FSM enters DONE on the edge where it reaches zero. A write wins over
    // a simultaneous read, and the read is simply dropped.
    always_comb begin
        w_stateNext = r_state;
        w_countNext = r_count;
        case (r_state)
            IDLE: begin
                if (wr_en) begin
                    w_countNext = WR_LOAD;
                    w_stateNext = (WR_LOAD == 4'd0) ? DONE : WR_WAIT;
                end else if (rd_en) begin
                    w_countNext = RD_LOAD;
                    w_stateNext = (RD_LOAD == 4'd0) ? DONE : RD_WAIT;
                end
            end
            WR_WAIT, RD_WAIT: begin
                if (r_count <= 4'd1) begin
                    w_countNext = 4'd0;
                    w_stateNext = DONE;
                end else begin
                    w_countNext = r_count - 4'd1;
                end
            end
            DONE: begin
                w_countNext = 4'd0;
                w_stateNext = IDLE;
            end
            default: begin
                w_countNext = 4'd0;
                w_stateNext = IDLE;
            end
        endcase
    end

    // Capture the accepted request. These registers describe the access in
    // flight and drive the done/error pulses while in DONE.
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            r_index   <= '0;
            r_dataIn  <= 32'd0;
            r_isWrite <= 1'b0;
            r_err     <= 1'b0;
        end else if (w_accept) begin
            r_index   <= sram_addr[IDX_W+1:2];
            r_dataIn  <= sram_data_in;
            r_isWrite <= wr_en;
            r_err     <= !w_addrInRange;
        end
    end

    // Read data register. Loaded only when a read completes, so writes and
    // idle cycles leave the last read value on the output.
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            r_dataOut <= 32'd0;
        end else if (w_enterDone && !w_accessIsWrite) begin
            r_dataOut <= w_accessInRange ? r_mem[w_accessIndex] : OOR_DATA;
        end
    end

    // Storage array. Deliberately not reset: contents survive reset and an
    // aborted write never reaches this point because DONE is never entered.
    always_ff @(posedge clock) begin
        if (w_enterDone && w_accessIsWrite && w_accessInRange) begin
            r_mem[w_accessIndex] <= w_accessData;
        end
    end

    // Outputs are decoded from registered state only, so they drop to zero
    // the moment reset asserts.
    assign busy            = !w_idle;
    assign sram_write_done = (r_state == DONE) && r_isWrite;
    assign sram_read_done  = (r_state == DONE) && !r_isWrite;
    assign sram_err        = (r_state == DONE) && r_err;
    assign sram_data_out   = r_dataOut;

endmodule

// File: tb/tb_sram_wait_state_memory.sv
// ============================================================================
// tb_sram_wait_state_memory
//
// Two instances are exercised side by side: instance 0 with default
// parameters and instance 1 with DEPTH_WORDS=16, WR_LATENCY=4, RD_LATENCY=1.
// A reference model tracks each instance as "edge of acceptance, edge of
// completion, earliest next acceptance" plus a sparse word store, and a
// compare process checks every output on every falling edge. Directed
// sequences pin the model with literal expectations before random traffic.
// ============================================================================
module tb_sram_wait_state_memory;

    localparam int DEP0 = 1024;
    localparam int WL0  = 1;
    localparam int RL0  = 2;
    localparam int DEP1 = 16;
    localparam int WL1  = 4;
    localparam int RL1  = 1;

    logic        clock = 1'b0;
    logic        rst   = 1'b1;

    logic        wrEn      [2];
    logic        rdEn      [2];
    logic [31:0] addr      [2];
    logic [31:0] dataIn    [2];
    logic [31:0] dataOut   [2];
    logic        writeDone [2];
    logic        readDone  [2];
    logic        errOut    [2];
    logic        busyOut   [2];

    int compared   = 0;
    int mismatched = 0;
    bit checkEn    = 1'b0;

    always #5 clock = ~clock;

    sram_wait_state_memory #(
        .DEPTH_WORDS(DEP0),
        .WR_LATENCY (WL0),
        .RD_LATENCY (RL0)
    ) dut0 (
        .clock          (clock),
        .rst            (rst),
        .sram_addr      (addr[0]),
        .sram_data_in   (dataIn[0]),
        .wr_en          (wrEn[0]),
        .rd_en          (rdEn[0]),
        .sram_data_out  (dataOut[0]),
        .sram_write_done(writeDone[0]),
        .sram_read_done (readDone[0]),
        .sram_err       (errOut[0]),
        .busy           (busyOut[0])
    );

    sram_wait_state_memory #(
        .DEPTH_WORDS(DEP1),
        .WR_LATENCY (WL1),
        .RD_LATENCY (RL1)
    ) dut1 (
        .clock          (clock),
        .rst            (rst),
        .sram_addr      (addr[1]),
        .sram_data_in   (dataIn[1]),
        .wr_en          (wrEn[1]),
        .rd_en          (rdEn[1]),
        .sram_data_out  (dataOut[1]),
        .sram_write_done(writeDone[1]),
        .sram_read_done (readDone[1]),
        .sram_err       (errOut[1]),
        .busy           (busyOut[1])
    );

    function automatic int depthOf(input int inst);
        return (inst == 0) ? DEP0 : DEP1;
    endfunction

    function automatic int latOf(input int inst, input bit isWrite);
        if (inst == 0) return isWrite ? WL0 : RL0;
        return isWrite ? WL1 : RL1;
    endfunction

    // Reference model state, counted in rising edges since time zero.
    int          mEdge = 0;
    int          nextFree [2];
    int          doneEdge [2];
    bit          pend     [2];
    bit          pWr      [2];
    bit          pErr     [2];
    int          pWord    [2];
    logic [31:0] pData    [2];
    logic [31:0] expData  [2];
    bit          expKnown [2];
    bit          expBusy  [2];
    bit          expWd    [2];
    bit          expRd    [2];
    bit          expErr   [2];
    logic [31:0] mMem [int];

    // Model update. An access accepted on edge E completes on edge
    // E+LAT-1 (its effect lands there and its done pulse follows it), keeps
    // the block busy over that span and blocks new acceptance until E+LAT+1.
    always @(posedge clock or posedge rst) begin
        int lat;
        int key;
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                pend[i]     = 1'b0;
                nextFree[i] = 0;
                expData[i]  = 32'd0;
                expKnown[i] = 1'b1;
                expBusy[i]  = 1'b0;
                expWd[i]    = 1'b0;
                expRd[i]    = 1'b0;
                expErr[i]   = 1'b0;
            end
        end else begin
            mEdge++;
            for (int i = 0; i < 2; i++) begin
                if ((wrEn[i] || rdEn[i]) && (mEdge >= nextFree[i])) begin
                    lat         = latOf(i, wrEn[i]);
                    pend[i]     = 1'b1;
                    pWr[i]      = wrEn[i];
                    pErr[i]     = (addr[i] >= 32'(4 * depthOf(i)));
                    pWord[i]    = int'(addr[i] >> 2);
                    pData[i]    = dataIn[i];
                    doneEdge[i] = mEdge + lat - 1;
                    nextFree[i] = mEdge + lat + 1;
                end
                if (pend[i] && (mEdge == doneEdge[i])) begin
                    key = i * 65536 + pWord[i];
                    if (pWr[i]) begin
                        if (!pErr[i]) mMem[key] = pData[i];
                    end else if (pErr[i]) begin
                        expData[i]  = 32'hDEAD_BEEF;
                        expKnown[i] = 1'b1;
                    end else if (mMem.exists(key)) begin
                        expData[i]  = mMem[key];
                        expKnown[i] = 1'b1;
                    end else begin
                        expKnown[i] = 1'b0;
                    end
                end
                expBusy[i] = pend[i] && (mEdge <= doneEdge[i]);
                expWd[i]   = pend[i] && (mEdge == doneEdge[i]) && pWr[i];
                expRd[i]   = pend[i] && (mEdge == doneEdge[i]) && !pWr[i];
                expErr[i]  = pend[i] && (mEdge == doneEdge[i]) && pErr[i];
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    // Cycle-by-cycle comparison against the model, away from the rising edge.
    always @(negedge clock) begin
        if (checkEn && !rst) begin
            for (int i = 0; i < 2; i++) begin
                checkOutput($sformatf("model busy%0d", i), 32'(busyOut[i]), 32'(expBusy[i]));
                checkOutput($sformatf("model wdone%0d", i), 32'(writeDone[i]), 32'(expWd[i]));
                checkOutput($sformatf("model rdone%0d", i), 32'(readDone[i]), 32'(expRd[i]));
                checkOutput($sformatf("model err%0d", i), 32'(errOut[i]), 32'(expErr[i]));
                if (expKnown[i]) begin
                    checkOutput($sformatf("model data%0d", i), dataOut[i], expData[i]);
                end
            end
        end
    end

    // Waits (bounded) until the model says the instance can accept, drives
    // the request for one rising edge and returns at the falling edge of the
    // cycle right after the accepting edge.
    task automatic applyStimulus(input int inst, input bit w, input bit r,
                                 input logic [31:0] a, input logic [31:0] d);
        int waitCycles;
        waitCycles = 0;
        while ((mEdge + 1 < nextFree[inst]) && (waitCycles < 100)) begin
            @(negedge clock);
            waitCycles++;
        end
        if (waitCycles >= 100) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL timeout%0d: got busy expected idle", inst);
        end
        #1;
        addr[inst]   = a;
        dataIn[inst] = d;
        wrEn[inst]   = w;
        rdEn[inst]   = r;
        @(negedge clock);
        wrEn[inst] = 1'b0;
        rdEn[inst] = 1'b0;
    endtask

    function automatic logic [31:0] pickAddr(input int inst);
        int          sel;
        logic [31:0] lowBits;
        sel     = $urandom_range(0, 7);
        lowBits = 32'($urandom_range(0, 3));
        if (sel <= 4) return (32'($urandom_range(0, 7)) << 2) | lowBits;
        if (sel == 5) return 32'(4 * depthOf(inst) - 4) | lowBits;
        if (sel == 6) return 32'(4 * depthOf(inst)) | lowBits;
        return $urandom | 32'h8000_0000;
    endfunction

    initial begin
        int inst;
        int op;
        int hold;
        for (int i = 0; i < 2; i++) begin
            wrEn[i]   = 1'b0;
            rdEn[i]   = 1'b0;
            addr[i]   = 32'd0;
            dataIn[i] = 32'd0;
        end

        // Outputs while reset is held.
        repeat (2) @(negedge clock);
        #1;
        checkOutput("rst data0", dataOut[0], 32'd0);
        checkOutput("rst busy0", 32'(busyOut[0]), 32'd0);
        checkOutput("rst wdone0", 32'(writeDone[0]), 32'd0);
        checkOutput("rst rdone0", 32'(readDone[0]), 32'd0);
        checkOutput("rst err0", 32'(errOut[0]), 32'd0);
        checkOutput("rst data1", dataOut[1], 32'd0);
        rst     = 1'b0;
        checkEn = 1'b1;

        // First request right after reset, then read it back.
        applyStimulus(0, 1'b1, 1'b0, 32'h10, 32'hA5A5_1234);
        checkOutput("first wdone", 32'(writeDone[0]), 32'd1);
        checkOutput("first werr", 32'(errOut[0]), 32'd0);
        checkOutput("first busy", 32'(busyOut[0]), 32'd1);
        applyStimulus(0, 1'b0, 1'b1, 32'h10, 32'd0);
        checkOutput("rd wait rdone", 32'(readDone[0]), 32'd0);
        checkOutput("rd wait busy", 32'(busyOut[0]), 32'd1);
        @(negedge clock);
        checkOutput("rd rdone", 32'(readDone[0]), 32'd1);
        checkOutput("rd data", dataOut[0], 32'hA5A5_1234);
        checkOutput("rd err", 32'(errOut[0]), 32'd0);

        // Simultaneous write and read: write only.
        applyStimulus(0, 1'b1, 1'b1, 32'h20, 32'h1111_2222);
        checkOutput("both wdone", 32'(writeDone[0]), 32'd1);
        checkOutput("both rdone", 32'(readDone[0]), 32'd0);
        applyStimulus(0, 1'b0, 1'b1, 32'h20, 32'd0);
        @(negedge clock);
        checkOutput("both readback", dataOut[0], 32'h1111_2222);

        // Out-of-range read and write.
        applyStimulus(0, 1'b1, 1'b0, 32'h0, 32'h0BAD_F00D);
        applyStimulus(0, 1'b0, 1'b1, 32'h1000, 32'd0);
        @(negedge clock);
        checkOutput("oor rdone", 32'(readDone[0]), 32'd1);
        checkOutput("oor rdata", dataOut[0], 32'hDEAD_BEEF);
        checkOutput("oor rerr", 32'(errOut[0]), 32'd1);
        applyStimulus(0, 1'b1, 1'b0, 32'h1000, 32'hCAFE_F00D);
        checkOutput("oor wdone", 32'(writeDone[0]), 32'd1);
        checkOutput("oor werr", 32'(errOut[0]), 32'd1);
        applyStimulus(0, 1'b0, 1'b1, 32'h0, 32'd0);
        @(negedge clock);
        checkOutput("word0 intact", dataOut[0], 32'h0BAD_F00D);

        // Write pulsed during RD_WAIT is ignored.
        applyStimulus(0, 1'b1, 1'b0, 32'h30, 32'h3333_3333);
        applyStimulus(0, 1'b0, 1'b1, 32'h30, 32'd0);
        #1;
        addr[0]   = 32'h30;
        dataIn[0] = 32'h4444_4444;
        wrEn[0]   = 1'b1;
        @(negedge clock);
        checkOutput("ignored wdone", 32'(writeDone[0]), 32'd0);
        checkOutput("ignored rdone", 32'(readDone[0]), 32'd1);
        checkOutput("ignored rdata", dataOut[0], 32'h3333_3333);
        wrEn[0] = 1'b0;
        applyStimulus(0, 1'b0, 1'b1, 32'h30, 32'd0);
        @(negedge clock);
        checkOutput("ignored mem", dataOut[0], 32'h3333_3333);

        // Reset in the middle of RD_WAIT.
        applyStimulus(0, 1'b1, 1'b0, 32'h40, 32'h55AA_55AA);
        applyStimulus(0, 1'b0, 1'b1, 32'h40, 32'd0);
        #1 rst = 1'b1;
        #1;
        checkOutput("abort busy", 32'(busyOut[0]), 32'd0);
        checkOutput("abort data", dataOut[0], 32'd0);
        checkOutput("abort rdone", 32'(readDone[0]), 32'd0);
        #1 rst = 1'b0;
        @(negedge clock);
        checkOutput("abort no rdone", 32'(readDone[0]), 32'd0);
        checkOutput("abort idle", 32'(busyOut[0]), 32'd0);
        applyStimulus(0, 1'b0, 1'b1, 32'h40, 32'd0);
        @(negedge clock);
        checkOutput("kept after rst", dataOut[0], 32'h55AA_55AA);

        // Last word of instance 0 with nonzero low address bits.
        applyStimulus(0, 1'b1, 1'b0, 32'hFFF, 32'h1234_5678);
        checkOutput("last werr", 32'(errOut[0]), 32'd0);
        applyStimulus(0, 1'b0, 1'b1, 32'hFFC, 32'd0);
        @(negedge clock);
        checkOutput("last rdata", dataOut[0], 32'h1234_5678);

        // Instance 1: write latency 4, read latency 1.
        applyStimulus(1, 1'b1, 1'b0, 32'h8, 32'h9ABC_DEF0);
        checkOutput("wl4 busy c1", 32'(busyOut[1]), 32'd1);
        checkOutput("wl4 wdone c1", 32'(writeDone[1]), 32'd0);
        repeat (2) @(negedge clock);
        checkOutput("wl4 wdone c3", 32'(writeDone[1]), 32'd0);
        @(negedge clock);
        checkOutput("wl4 wdone c4", 32'(writeDone[1]), 32'd1);
        checkOutput("wl4 busy c4", 32'(busyOut[1]), 32'd1);
        applyStimulus(1, 1'b0, 1'b1, 32'h8, 32'd0);
        checkOutput("rl1 rdone", 32'(readDone[1]), 32'd1);
        checkOutput("rl1 busy", 32'(busyOut[1]), 32'd1);
        checkOutput("rl1 data", dataOut[1], 32'h9ABC_DEF0);
        applyStimulus(1, 1'b0, 1'b1, 32'h40, 32'd0);
        checkOutput("rl1 oor data", dataOut[1], 32'hDEAD_BEEF);
        checkOutput("rl1 oor err", 32'(errOut[1]), 32'd1);

        // Random traffic, including requests held across busy periods.
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 59) == 0) begin
                #1 rst = 1'b1;
                #1 rst = 1'b0;
            end
            inst = $urandom_range(0, 1);
            op   = $urandom_range(0, 9);
            hold = $urandom_range(1, 3);
            #1;
            addr[inst]   = pickAddr(inst);
            dataIn[inst] = $urandom;
            wrEn[inst]   = (op < 4);
            rdEn[inst]   = (op >= 3) && (op < 8);
            repeat (hold) @(negedge clock);
            wrEn[inst] = 1'b0;
            rdEn[inst] = 1'b0;
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 4)) @(negedge clock);
        end

        repeat (10) @(negedge clock);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
